// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: scan coordinates and pixel strobe out, selector colour back in, VGA pin signals out.
interface vga_timing_gen_if;
  logic [15:0] x;
  logic [15:0] y;
  logic        pix_en;
  logic [2:0]  rgb_in;
  logic        hsync;
  logic        vsync;
  logic [2:0]  vga_rgb;
  logic        video_on;
  logic        line_start;
  logic        frame_start;
  modport master (
    output x, y, pix_en, hsync, vsync, vga_rgb, video_on, line_start, frame_start,
    input  rgb_in
  );
  modport slave (
    input  x, y, pix_en, hsync, vsync, vga_rgb, video_on, line_start, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with pixel strobe, plus a sync/blank delay line that keeps the
// pins aligned with the registered colour coming back from the pixel selector.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2,
  parameter bit SYNC_POL   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master bus
);
  localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int          PD      = PIPE_DELAY;
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END  = 16'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] r_div;
  logic [15:0]   r_h_cnt, r_v_cnt;
  logic [PD-1:0] r_hs_d, r_vs_d, r_act_d;
  logic [2:0]    r_rgb;
  logic          r_ls, r_fs;
  logic          w_pix_en, w_h_last, w_v_last, w_active, w_hs, w_vs;
  logic [PD-1:0] w_hs_nx, w_vs_nx, w_act_nx;
  always_comb begin
    w_pix_en = (CLK_DIV == 1) || (r_div == DW'(CLK_DIV - 1));
    w_h_last = r_h_cnt == H_LAST;
    w_v_last = r_v_cnt == V_LAST;
    w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_hs     = (r_h_cnt >= HS_BEG && r_h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    w_vs     = (r_v_cnt >= VS_BEG && r_v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    w_hs_nx  = (r_hs_d << 1) | PD'(w_hs);
    w_vs_nx  = (r_vs_d << 1) | PD'(w_vs);
    w_act_nx = (r_act_d << 1) | PD'(w_active);
  end
  // The colour register loads alongside the last delay stage, so it is gated by the active bit entering that stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs_d  <= {PD{~SYNC_POL}};
      r_vs_d  <= {PD{~SYNC_POL}};
      r_act_d <= '0;
      r_rgb   <= '0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + DW'(1);
      r_ls  <= w_pix_en && w_h_last;
      r_fs  <= w_pix_en && w_h_last && w_v_last;
      if (w_pix_en) begin
        r_h_cnt <= w_h_last ? '0 : r_h_cnt + 16'd1;
        r_v_cnt <= !w_h_last ? r_v_cnt : (w_v_last ? '0 : r_v_cnt + 16'd1);
        r_hs_d  <= w_hs_nx;
        r_vs_d  <= w_vs_nx;
        r_act_d <= w_act_nx;
        r_rgb   <= w_act_nx[PD-1] ? bus.rgb_in : 3'b000;
      end
    end
  end
  assign bus.x           = r_h_cnt;
  assign bus.y           = r_v_cnt;
  assign bus.pix_en      = w_pix_en;
  assign bus.hsync       = r_hs_d[PD-1];
  assign bus.vsync       = r_vs_d[PD-1];
  assign bus.video_on    = r_act_d[PD-1];
  assign bus.vga_rgb     = r_rgb;
  assign bus.line_start  = r_ls;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked every clk against a closed-form raster model,
// plus a boundary table and line/frame period measurements.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        pix_en;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic        von;
    logic        ls;
    logic        fs;
  } out_t;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, cd, d;
    bit pol;
  } cfg_t;
  typedef struct {
    int x, y;
    bit hs, vs, von;
    logic [2:0] rgb;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vga_timing_gen_if bus_a ();
  vga_timing_gen_if bus_b ();
  vga_timing_gen_if bus_c ();
  vga_timing_gen u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .PIPE_DELAY(2), .SYNC_POL(1'b0)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(1), .PIPE_DELAY(3), .SYNC_POL(1'b1)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
  out_t act [3];
  assign act[0] = {bus_a.x, bus_a.y, bus_a.pix_en, bus_a.hsync, bus_a.vsync, bus_a.vga_rgb,
                   bus_a.video_on, bus_a.line_start, bus_a.frame_start};
  assign act[1] = {bus_b.x, bus_b.y, bus_b.pix_en, bus_b.hsync, bus_b.vsync, bus_b.vga_rgb,
                   bus_b.video_on, bus_b.line_start, bus_b.frame_start};
  assign act[2] = {bus_c.x, bus_c.y, bus_c.pix_en, bus_c.hsync, bus_c.vsync, bus_c.vga_rgb,
                   bus_c.video_on, bus_c.line_start, bus_c.frame_start};
  cfg_t       cfg [3];
  vec_t       tv [13];
  logic [2:0] rnd [256];
  int c, mode, n_cmp, n_bad;
  int a_last, a_hs, b_last, b_vs, c_last, c_hs;
  function automatic int h_total(cfg_t g);
    return g.ha + g.hf + g.hs + g.hb;
  endfunction
  function automatic int v_total(cfg_t g);
    return g.va + g.vf + g.vs + g.vb;
  endfunction
  // Colour the selector produces for absolute pixel number j since release.
  function automatic logic [2:0] colour(int j, int ht);
    return mode == 0 ? 3'b101 : mode == 1 ? 3'(j % ht) : rnd[j % 256];
  endfunction
  function automatic out_t model(cfg_t g, int cc, bit in_rst);
    out_t o;
    int ht, vt, k, ph, kd, xd, yd;
    ht = h_total(g);
    vt = v_total(g);
    o = '0;
    o.hs = ~g.pol;
    o.vs = ~g.pol;
    o.pix_en = g.cd == 1;
    if (in_rst) return o;
    k  = cc / g.cd;
    ph = cc % g.cd;
    o.x = 16'(k % ht);
    o.y = 16'((k / ht) % vt);
    o.pix_en = ph == g.cd - 1;
    o.ls = k > 0 && k % ht == 0 && ph == 0;
    o.fs = k > 0 && k % (ht * vt) == 0 && ph == 0;
    kd = k - g.d;
    if (kd >= 0) begin
      xd = kd % ht;
      yd = (kd / ht) % vt;
      o.von = xd < g.ha && yd < g.va;
      o.hs = (xd >= g.ha + g.hf && xd < g.ha + g.hf + g.hs) ? g.pol : ~g.pol;
      o.vs = (yd >= g.va + g.vf && yd < g.va + g.vf + g.vs) ? g.pol : ~g.pol;
      o.rgb = o.von ? colour(kd, ht) : 3'b000;
    end
    return o;
  endfunction
  function automatic logic [2:0] rgb_for(cfg_t g);
    int j;
    j = c / g.cd - (g.d - 1);
    return (!rst_n || j < 0) ? 3'b000 : colour(j, h_total(g));
  endfunction
  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic check_all(input bit in_rst);
    for (int i = 0; i < 3; i++)
      cmp($sformatf("dut%0d outputs {x,y,pix,hs,vs,rgb,von,ls,fs} c=%0d", i, c),
          64'(act[i]), 64'(model(cfg[i], c, in_rst)));
  endtask
  task automatic measure();
    if (bus_a.line_start) begin
      if (a_last >= 0) begin
        cmp("A line period clk", 64'(c - a_last), 64'd1600);
        cmp("A hsync low strobes", 64'(a_hs), 64'd96);
      end
      a_last = c;
      a_hs = 0;
    end
    if (bus_a.pix_en && !bus_a.hsync) a_hs++;
    if (bus_b.frame_start) begin
      if (b_last >= 0) begin
        cmp("B frame period clk", 64'(c - b_last), 64'd960);
        cmp("B vsync low clk", 64'(b_vs), 64'd128);
      end
      b_last = c;
      b_vs = 0;
    end
    if (!bus_b.vsync) b_vs++;
    if (bus_c.line_start) begin
      if (c_last >= 0) begin
        cmp("C line period clk", 64'(c - c_last), 64'd32);
        cmp("C hsync high strobes", 64'(c_hs), 64'd6);
      end
      c_last = c;
      c_hs = 0;
    end
    if (bus_c.hsync) c_hs++;
  endtask
  task automatic drive();
    bus_a.rgb_in = rgb_for(cfg[0]);
    bus_b.rgb_in = rgb_for(cfg[1]);
    bus_c.rgb_in = rgb_for(cfg[2]);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) c++;
    #1 drive();
    @(negedge clk);
    check_all(!rst_n);
    if (rst_n) measure();
  endtask
  // Reset lands mid clk-high so the async clear is observed before any further edge.
  task automatic do_reset(input int hold, input int new_mode);
    @(posedge clk);
    #2 rst_n = 1'b0;
    c = 0;
    drive();
    #1 check_all(1'b1);
    @(negedge clk);
    repeat (hold) tick();
    mode = new_mode;
    a_last = -1; b_last = -1; c_last = -1;
    a_hs = 0; b_vs = 0; c_hs = 0;
    rst_n = 1'b1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int kb;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0};
    cfg[1] = '{16, 4, 6, 6, 8, 2, 2, 3, 2, 2, 1'b0};
    cfg[2] = '{16, 4, 6, 6, 8, 2, 2, 3, 1, 3, 1'b1};
    tv[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 3'b101};
    tv[1]  = '{15, 7,  1'b1, 1'b1, 1'b1, 3'b101};
    tv[2]  = '{16, 0,  1'b1, 1'b1, 1'b0, 3'b000};
    tv[3]  = '{19, 3,  1'b1, 1'b1, 1'b0, 3'b000};
    tv[4]  = '{20, 3,  1'b0, 1'b1, 1'b0, 3'b000};
    tv[5]  = '{25, 3,  1'b0, 1'b1, 1'b0, 3'b000};
    tv[6]  = '{26, 3,  1'b1, 1'b1, 1'b0, 3'b000};
    tv[7]  = '{5,  8,  1'b1, 1'b1, 1'b0, 3'b000};
    tv[8]  = '{5,  9,  1'b1, 1'b1, 1'b0, 3'b000};
    tv[9]  = '{5,  10, 1'b1, 1'b0, 1'b0, 3'b000};
    tv[10] = '{22, 11, 1'b0, 1'b0, 1'b0, 3'b000};
    tv[11] = '{5,  12, 1'b1, 1'b1, 1'b0, 3'b000};
    tv[12] = '{31, 14, 1'b1, 1'b1, 1'b0, 3'b000};
    for (int i = 0; i < 256; i++) rnd[i] = 3'($urandom);
    n_cmp = 0;
    n_bad = 0;
    c = 0;
    mode = 2;
    do_reset(3, 2);
    repeat (4900) tick();
    do_reset(1, 0);
    repeat (1700) tick();
    do_reset(0, 1);
    repeat (1700) tick();
    for (int i = 0; i < 13; i++) begin
      do_reset(2, 0);
      kb = tv[i].y * 32 + tv[i].x;
      while (c < kb + 3) tick();
      cmp($sformatf("tbl%0d C hsync", i), 64'(bus_c.hsync), 64'(!tv[i].hs));
      cmp($sformatf("tbl%0d C vsync", i), 64'(bus_c.vsync), 64'(!tv[i].vs));
      cmp($sformatf("tbl%0d C video_on", i), 64'(bus_c.video_on), 64'(tv[i].von));
      cmp($sformatf("tbl%0d C vga_rgb", i), 64'(bus_c.vga_rgb), 64'(tv[i].rgb));
      while (c < 2 * (kb + 2)) tick();
      cmp($sformatf("tbl%0d B hsync", i), 64'(bus_b.hsync), 64'(tv[i].hs));
      cmp($sformatf("tbl%0d B vsync", i), 64'(bus_b.vsync), 64'(tv[i].vs));
      cmp($sformatf("tbl%0d B video_on", i), 64'(bus_b.video_on), 64'(tv[i].von));
      cmp($sformatf("tbl%0d B vga_rgb", i), 64'(bus_b.vga_rgb), 64'(tv[i].rgb));
    end
    for (int i = 0; i < 6; i++) begin
      do_reset(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(20, 1500)) tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
